// File: rtl/joy_db15_pkg.sv
// Shared types and constants for the DB15 serial joystick responder.
package joy_db15_pkg;

  // Button bits per player and full frame length on the wire.
  localparam int unsigned DB15_NBITS      = 12;
  localparam int unsigned DB15_FRAME_BITS = 24;

  // Button bit positions within one player's word (active-high pressed).
  localparam int unsigned BTN_R      = 0;
  localparam int unsigned BTN_L      = 1;
  localparam int unsigned BTN_D      = 2;
  localparam int unsigned BTN_U      = 3;
  localparam int unsigned BTN_A      = 4;
  localparam int unsigned BTN_B      = 5;
  localparam int unsigned BTN_C      = 6;
  localparam int unsigned BTN_X      = 7;
  localparam int unsigned BTN_Y      = 8;
  localparam int unsigned BTN_Z      = 9;
  localparam int unsigned BTN_START  = 10;
  localparam int unsigned BTN_SELECT = 11;

  // Responder frame state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } resp_state_t;

endpackage

// File: rtl/joy_db15_sync.sv
// Two-flop synchronizer, optional 3-sample stability filter, rising-edge detect.
// Optional feature: DB15_RESP_DEGLITCH_EN enables the stability filter.
module joy_db15_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level_c,
  output logic o_rise_c
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic w_level;

  // Bring the asynchronous pin into the i_clk domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

`ifdef DB15_RESP_DEGLITCH_EN
  logic [1:0] r_hist;
  logic       r_held;
  logic       w_all_eq;

  // Accept a new level only when three consecutive samples agree.
  assign w_all_eq = (r_sync == r_hist[0]) && (r_sync == r_hist[1]);
  assign w_level  = w_all_eq ? r_sync : r_held;

  // Sample history and last accepted level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hist <= {2{RST_VAL}};
      r_held <= RST_VAL;
    end else begin
      r_hist <= {r_hist[0], r_sync};
      r_held <= w_level;
    end
  end
`else
  assign w_level = r_sync;
`endif

  // Previous conditioned level for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= RST_VAL;
    end else begin
      r_prev <= w_level;
    end
  end

  assign o_level_c = w_level;
  assign o_rise_c  = w_level & ~r_prev;

endmodule

// File: rtl/joy_db15_responder.sv
// Device-side DB15 serial joystick responder: captures two players' buttons on
// load, then shifts them out active-low, one bit per received clock edge.
// Optional feature: DB15_RESP_DEGLITCH_EN adds a 3-sample input filter.
module joy_db15_responder
  import joy_db15_pkg::*;
#(
  parameter int unsigned NBITS_PER_PLAYER = DB15_NBITS
) (
  input  logic                        clk_sys,
  input  logic                        reset_n,
  input  logic                        joy_clk_in,
  input  logic                        joy_load_in,
  input  logic [NBITS_PER_PLAYER-1:0] p1_buttons,
  input  logic [NBITS_PER_PLAYER-1:0] p2_buttons,
  output logic                        joy_data_out,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        overrun
);

  localparam int unsigned FRAME_BITS = 2 * NBITS_PER_PLAYER;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS);

  resp_state_t           r_state;
  resp_state_t           w_state_nxt;
  logic [FRAME_BITS-1:0] r_shreg;
  logic [FRAME_BITS-1:0] w_shreg_nxt;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [CNT_W-1:0]      w_bit_cnt_nxt;
  logic                  r_overrun;
  logic                  w_overrun_nxt;
  logic                  r_frame_done;
  logic                  w_frame_done_nxt;
  logic                  r_busy;
  logic                  w_busy_nxt;
  logic                  r_data_out;
  logic                  w_data_nxt;

  logic w_clk_lvl;
  logic w_clk_rise;
  logic w_load_lvl;
  logic w_load_rise;
  logic w_unused_sync;

  // Serial clock conditioning; idles low.
  joy_db15_sync #(
    .RST_VAL (1'b0)
  ) u_sync_clk (
    .i_clk     (clk_sys),
    .i_rst_n   (reset_n),
    .i_async   (joy_clk_in),
    .o_level_c (w_clk_lvl),
    .o_rise_c  (w_clk_rise)
  );

  // Load strobe conditioning; active-low, idles high.
  joy_db15_sync #(
    .RST_VAL (1'b1)
  ) u_sync_load (
    .i_clk     (clk_sys),
    .i_rst_n   (reset_n),
    .i_async   (joy_load_in),
    .o_level_c (w_load_lvl),
    .o_rise_c  (w_load_rise)
  );

  // Clock level and load edge are not needed by the frame logic.
  assign w_unused_sync = &{1'b0, w_clk_lvl, w_load_rise};

  // Next-state, shift register, counter and output decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_shreg_nxt      = r_shreg;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_overrun_nxt    = r_overrun;
    w_frame_done_nxt = 1'b0;

    if (!w_load_lvl) begin
      // Transparent parallel load; a coincident clock edge is discarded.
      w_state_nxt   = LOAD;
      w_shreg_nxt   = ~{p2_buttons, p1_buttons};
      w_bit_cnt_nxt = '0;
      w_overrun_nxt = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nxt = IDLE;
        end
        LOAD: begin
          w_state_nxt = SHIFT;
        end
        SHIFT: begin
          if (w_clk_rise) begin
            w_shreg_nxt   = {1'b1, r_shreg[FRAME_BITS-1:1]};
            w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
            if (w_bit_cnt_nxt == CNT_LAST) begin
              w_state_nxt      = DONE;
              w_frame_done_nxt = 1'b1;
            end
          end
        end
        DONE: begin
          // Counter holds at its terminal value; extra edges only flag overrun.
          if (w_clk_rise) begin
            w_overrun_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt == SHIFT);
    w_data_nxt = ((w_state_nxt == LOAD) || (w_state_nxt == SHIFT)) ? w_shreg_nxt[0] : 1'b1;
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_shreg      <= '1;
      r_bit_cnt    <= '0;
      r_overrun    <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
      r_data_out   <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_shreg      <= w_shreg_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_overrun    <= w_overrun_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_busy       <= w_busy_nxt;
      r_data_out   <= w_data_nxt;
    end
  end

  assign joy_data_out = r_data_out;
  assign busy         = r_busy;
  assign frame_done   = r_frame_done;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_joy_db15_responder.sv
// Directed bench for joy_db15_responder.
module tb_joy_db15_responder;

`ifdef DB15_RESP_DEGLITCH_EN
  localparam int LAT           = 5;
  localparam int GLITCH_SHIFTS = 0;
  localparam int LOAD_MIN      = 3;
`else
  localparam int LAT           = 3;
  localparam int GLITCH_SHIFTS = 1;
  localparam int LOAD_MIN      = 1;
`endif

  logic        clk_sys     = 1'b0;
  logic        reset_n     = 1'b0;
  logic        joy_clk_in  = 1'b0;
  logic        joy_load_in = 1'b1;
  logic [11:0] p1          = 12'h000;
  logic [11:0] p2          = 12'h000;
  logic        joy_data_out;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  int n_chk  = 0;
  int n_fail = 0;
  int fd_cnt = 0;
  int fd0    = 0;

  joy_db15_responder dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .joy_clk_in   (joy_clk_in),
    .joy_load_in  (joy_load_in),
    .p1_buttons   (p1),
    .p2_buttons   (p2),
    .joy_data_out (joy_data_out),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun      (overrun)
  );

  always #5 clk_sys = ~clk_sys;

  // Count cycles with frame_done high.
  always @(negedge clk_sys) begin
    if (reset_n && frame_done) fd_cnt = fd_cnt + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected wire bit i of a frame: active-low, p1 first, ones past the end.
  function automatic logic exp_bit(input logic [11:0] a, input logic [11:0] b, input int i);
    logic [23:0] f;
    f = ~{b, a};
    if (i < 24) return f[i];
    return 1'b1;
  endfunction

  task automatic do_load(input logic [11:0] a, input logic [11:0] b);
    p1 = a;
    p2 = b;
    joy_load_in = 1'b0;
    cyc(8);
    joy_load_in = 1'b1;
    cyc(10);
  endtask

  task automatic edge_cycle();
    joy_clk_in = 1'b1;
    cyc(10);
    joy_clk_in = 1'b0;
    cyc(10);
  endtask

  // Sample each bit before its clock edge, then apply the edge.
  task automatic run_frame(input string tag, input logic [11:0] a, input logic [11:0] b,
                           input int first, input int n);
    for (int k = first; k < first + n; k++) begin
      check($sformatf("%s_bit%0d", tag, k), 32'(joy_data_out), 32'(exp_bit(a, b, k)));
      edge_cycle();
    end
  endtask

  initial begin
    // Reset values
    cyc(3);
    check("rst_data", 32'(joy_data_out), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_ovr",  32'(overrun), 32'd0);
    reset_n = 1'b1;
    cyc(3);
    check("idle_data", 32'(joy_data_out), 32'd1);

    // Full frame; buttons changed after load must not matter
    do_load(12'h001, 12'h800);
    p1 = 12'h0FE;
    p2 = 12'h7FF;
    check("ff_busy", 32'(busy), 32'd1);
    fd0 = fd_cnt;
    check("ff_bit0", 32'(joy_data_out), 32'd0);
    joy_clk_in = 1'b1;
    cyc(LAT - 1);
    check("ff_lat_old", 32'(joy_data_out), 32'd0);
    cyc(1);
    check("ff_lat_new", 32'(joy_data_out), 32'd1);
    cyc(10 - LAT);
    joy_clk_in = 1'b0;
    cyc(10);
    run_frame("ff", 12'h001, 12'h800, 1, 22);
    check("ff_no_early_done", 32'(fd_cnt), 32'(fd0));
    run_frame("ff", 12'h001, 12'h800, 23, 1);
    check("ff_done_once", 32'(fd_cnt), 32'(fd0 + 1));
    check("ff_busy_end", 32'(busy), 32'd0);
    check("ff_data_end", 32'(joy_data_out), 32'd1);
    check("ff_no_ovr", 32'(overrun), 32'd0);

    // Overrun: edges 25 and 26
    run_frame("ovr", 12'h001, 12'h800, 24, 2);
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_no_done", 32'(fd_cnt), 32'(fd0 + 1));
    do_load(12'h000, 12'h000);
    check("ovr_clr", 32'(overrun), 32'd0);

    // Load mid-frame aborts and restarts
    do_load(12'h001, 12'h800);
    fd0 = fd_cnt;
    run_frame("mid_a", 12'h001, 12'h800, 0, 10);
    do_load(12'h000, 12'h800);
    check("mid_bit0", 32'(joy_data_out), 32'd1);
    check("mid_busy", 32'(busy), 32'd1);
    run_frame("mid_b", 12'h000, 12'h800, 0, 23);
    check("mid_no_done", 32'(fd_cnt), 32'(fd0));
    run_frame("mid_b", 12'h000, 12'h800, 23, 1);
    check("mid_done", 32'(fd_cnt), 32'(fd0 + 1));

    // Clock edge and load low together: load wins, count restarts at 0
    do_load(12'h001, 12'h800);
    run_frame("sim_a", 12'h001, 12'h800, 0, 3);
    fd0 = fd_cnt;
    joy_clk_in  = 1'b1;
    joy_load_in = 1'b0;
    cyc(LOAD_MIN);
    joy_load_in = 1'b1;
    cyc(9);
    check("sim_data", 32'(joy_data_out), 32'd0);
    check("sim_busy", 32'(busy), 32'd1);
    joy_clk_in = 1'b0;
    cyc(10);
    run_frame("sim_b", 12'h001, 12'h800, 0, 23);
    check("sim_no_done", 32'(fd_cnt), 32'(fd0));
    run_frame("sim_b", 12'h001, 12'h800, 23, 1);
    check("sim_done", 32'(fd_cnt), 32'(fd0 + 1));

    // One-cycle glitch on the serial clock
    do_load(12'h001, 12'h800);
    joy_clk_in = 1'b1;
    cyc(1);
    joy_clk_in = 1'b0;
    cyc(12);
    check("glitch_data", 32'(joy_data_out), 32'(exp_bit(12'h001, 12'h800, GLITCH_SHIFTS)));
    check("glitch_busy", 32'(busy), 32'd1);

    // Asynchronous reset mid-frame
    do_load(12'h020, 12'h000);
    run_frame("rmid", 12'h020, 12'h000, 0, 5);
    check("rmid_pre_data", 32'(joy_data_out), 32'd0);
    check("rmid_pre_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rmid_data", 32'(joy_data_out), 32'd1);
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_ovr",  32'(overrun), 32'd0);
    check("rmid_done", 32'(frame_done), 32'd0);
    cyc(2);
    reset_n = 1'b1;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/joy_db15_responder.md
# joy_db15_responder

Device-side model of the DB15 serial joystick adapter: the responder at the far end of the clock/load/data link that the core's DB15 reader drives. On a load strobe it captures two players' button words, then presents them bit-serially on the data line, one bit per received clock edge, active-low as on the real shift-register chain. It sits in the bench harness and in loopback/bridge builds, wired to the reader's clock and load outputs and its data input.

## Interface
- NBITS_PER_PLAYER, 12, button bits per player. Total frame length is 2×NBITS_PER_PLAYER.
- clk_sys  in  1  system clock, 40–50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- joy_clk_in  in  1  serial clock from the reader (asynchronous to clk_sys).
- joy_load_in  in  1  load strobe from the reader, active-low (asynchronous).
- p1_buttons  in  NBITS_PER_PLAYER  player 1 buttons, active-high pressed. Bit 0 = R, 1 = L, 2 = D, 3 = U, 4 = A … 11 = Select.
- p2_buttons  in  NBITS_PER_PLAYER  player 2 buttons, same mapping.
- joy_data_out  out  1  serial data to the reader, active-low (0 = pressed).
- busy  out  1  frame in progress: loaded and not all bits yet shifted.
- frame_done  out  1  one-cycle pulse when the last frame bit is shifted out.
- overrun  out  1  sticky; clock edges were received past the frame end. Cleared by the next load.

## Operation
- **Input conditioning:** joy_clk_in and joy_load_in each pass through a 2-flop synchronizer into clk_sys. A rising-edge detector follows the synchronized clock.
- **States:** IDLE, LOAD, SHIFT, DONE.
- **IDLE:** joy_data_out = 1. Entered at reset.
- **LOAD:** entered whenever the synchronized load is low, from any state.
  - The shift register loads continuously: shreg = ~{p2_buttons, p1_buttons}. This is transparent, like a 74HC165 with its parallel-load input held low.
  - bit_cnt = 0, overrun cleared.
  - joy_data_out = ~p1_buttons[0].
- **LOAD → SHIFT:** on the synchronized load returning high.
- **SHIFT:**
  - Each detected clock rising edge shifts shreg right by one and fills the top bit with 1 (serial input tied high).
  - bit_cnt increments on each shift.
  - joy_data_out is always shreg[0].
  - Wire order: p1 bit 0 … p1 bit 11, then p2 bit 0 … p2 bit 11.
- **SHIFT → DONE:** when bit_cnt reaches 2×NBITS_PER_PLAYER. frame_done pulses in the same cycle that bit_cnt reaches its terminal value.
- **DONE:**
  - joy_data_out = 1.
  - A further clock edge sets overrun. bit_cnt saturates.
  - Stays in DONE until a load.
- **busy:** 1 in SHIFT only.
- **Arithmetic:** bit_cnt width is $clog2(2×NBITS_PER_PLAYER+1). No wrap.

## Timing
- **Reset values:**
  - joy_data_out = 1, busy = 0, frame_done = 0, overrun = 0.
  - shreg = all ones, bit_cnt = 0, state = IDLE.
- **Latency:** a pin-level change on joy_clk_in or joy_load_in affects joy_data_out 3 clk_sys cycles later (2 synchronizer flops plus 1 registered output).
- **Reader constraint:** joy_clk_in high and low phases must each be ≥ 4 clk_sys cycles.
- **Load and clock together:** if a load-low and a clock edge appear in the same cycle, load wins and the shift is discarded.
- **Load mid-frame:** aborts the frame and reloads. No frame_done is produced.
- **Button changes:** changes on p1/p2_buttons outside LOAD have no effect until the next load.
- **Reset mid-frame:** outputs return to their reset values immediately (asynchronous).

## Configuration
- **DB15_RESP_DEGLITCH_EN defined:** after synchronization, each input additionally passes a 3-sample majority/stability filter. A level is accepted only after 3 equal consecutive samples. Latency becomes 5 cycles and the minimum phase becomes 6 cycles.
- **DB15_RESP_DEGLITCH_EN not defined:** no filter; timing is exactly as stated above.

## Structure
- A shared package joy_db15_pkg holds:
  - state enum resp_state_t (IDLE, LOAD, SHIFT, DONE);
  - the button bit-index constants (BTN_R = 0 … BTN_SELECT = 11);
  - localparam DB15_FRAME_BITS = 24.
- One sub-module, joy_db15_sync: synchronizer plus optional deglitch plus rising-edge detect, instantiated once for the clock and once for the load.

## Test plan
- **Reset:** assert reset_n = 0 mid-operation → joy_data_out = 1, busy = 0, overrun = 0 in the same cycle.
- **Full frame:**
  - Stimulus: p1 = 12'h001, p2 = 12'h800; pulse load low for 8 cycles, then 24 clocks at 10-cycle phases.
  - Expected sampled stream (pre-edge): 0, 1×22, 0.
  - frame_done pulses once, after edge 24.
- **Overrun:** apply 26 clocks after a load → bits 25–26 read 1, overrun = 1. A subsequent load clears it.
- **Load mid-frame:** load again after 10 edges with p1 = 12'h000 → the stream restarts at bit 0 = 1 and no frame_done pulse occurs.
- **Simultaneous clock edge and load low:** bit_cnt stays 0 and joy_data_out = ~p1[0].
- **Glitch rejection (DB15_RESP_DEGLITCH_EN):** a 1-cycle high glitch on joy_clk_in causes no shift. The same glitch without the macro causes 1 shift.
